// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_pkg : shared types, constants and round-robin helper for disp blocks   |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
package disp_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } disp_state_t;

   localparam int DISP_W         = 16;
   localparam int DEF_SCAN_DIV   = 50000;
   localparam int DEF_HOLD_TICKS = 1000;
   localparam int MAX_NREQ       = 8;

   // First set request strictly after ptr, wrapping mod nreq; ptr itself is the last candidate.
   function automatic logic [2:0] next_rr(input logic [MAX_NREQ-1:0] req,
                                          input logic [2:0]          ptr,
                                          input int                  nreq);
      logic [2:0] idx;
      logic       found;
      logic [3:0] c;
      idx   = ptr;
      found = 1'b0;
      for (int k = 1; k <= MAX_NREQ; k++) begin
         c = {1'b0, ptr} + 4'(k);
         if (c >= 4'(nreq)) c = c - 4'(nreq);
         if (!found && (k <= nreq) && req[c[2:0]]) begin
            idx   = c[2:0];
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_prescaler : free-running SCAN_DIV divider, 1-cycle tick per period      |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module disp_prescaler #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int PW = $clog2(SCAN_DIV);

   logic [PW-1:0] r_pcnt;
   logic          r_tick;
   logic          w_last;

   assign w_last = (r_pcnt == PW'(SCAN_DIV - 1));
   assign tick   = r_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_last;
         r_pcnt <= w_last ? '0 : r_pcnt + PW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_arbiter : round-robin owner of the 7-seg display with min hold time    |
// | Optional freeze input enabled by macro DISP_FREEZE_EN.  Revision : 1.0       |
// +----------------------------------------------------------------------------+
module disp_arbiter
   import disp_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int SCAN_DIV   = DEF_SCAN_DIV,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef DISP_FREEZE_EN
   input  logic                 freeze,
`endif
   input  logic [NREQ-1:0]      req,
   input  logic [DISP_W*NREQ-1:0] src_data,
   output logic [NREQ-1:0]      grant,
   output logic [2:0]           cur_src,
   output logic [DISP_W-1:0]    disp_data,
   output logic                 disp_vld,
   output logic                 scan_tick
);

   localparam int HW = $clog2(HOLD_TICKS + 1);

   disp_state_t         r_state, w_state_n;
   logic [2:0]          r_cur, w_cur_n;
   logic [2:0]          r_rr, w_rr_n;
   logic [NREQ-1:0]     r_grant, w_grant_n;
   logic [HW-1:0]       r_hold, w_hold_n;
   logic [DISP_W-1:0]   r_data, w_data_n;

   logic                w_freeze;
   logic                w_tick;
   logic [MAX_NREQ-1:0] w_req_ext;
   logic [2:0]          w_nxt_idle;
   logic [2:0]          w_nxt_show;
   logic                w_req_cur;
   logic                w_others;
   logic                w_hold_full;
   logic [DISP_W-1:0]   w_src_sel;

`ifdef DISP_FREEZE_EN
   assign w_freeze = freeze;
`else
   assign w_freeze = 1'b0;
`endif

   generate
      if (NREQ < MAX_NREQ) begin : g_req_pad
         assign w_req_ext = {{(MAX_NREQ - NREQ){1'b0}}, req};
      end else begin : g_req_full
         assign w_req_ext = req;
      end
   endgenerate

   disp_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_nxt_idle  = next_rr(w_req_ext, r_rr, NREQ);
   assign w_nxt_show  = next_rr(w_req_ext, r_cur, NREQ);
   assign w_req_cur   = |(req & r_grant);
   assign w_others    = |(req & ~r_grant);
   assign w_hold_full = (r_hold == HW'(HOLD_TICKS));
   assign w_src_sel   = src_data[DISP_W*int'(r_cur) +: DISP_W];

   always_comb begin
      w_state_n = r_state;
      w_cur_n   = r_cur;
      w_rr_n    = r_rr;
      w_grant_n = r_grant;
      w_hold_n  = r_hold;
      w_data_n  = r_data;
      case (r_state)
         ST_IDLE: begin
            w_data_n = '0;
            if (|req) begin
               w_state_n = ST_SHOW;
               w_cur_n   = w_nxt_idle;
               w_rr_n    = w_nxt_idle;
               w_grant_n = NREQ'(1) << w_nxt_idle;
               w_hold_n  = '0;
            end
         end
         ST_SHOW: begin
            if (!w_freeze) begin
               w_data_n = w_src_sel;
               // Owner release (A) is checked before hold expiry (B).
               if (!w_req_cur && !w_others) begin
                  w_state_n = ST_IDLE;
                  w_cur_n   = '0;
                  w_grant_n = '0;
                  w_hold_n  = '0;
                  w_data_n  = '0;
               end else if (!w_req_cur || (w_hold_full && w_others)) begin
                  w_cur_n   = w_nxt_show;
                  w_rr_n    = w_nxt_show;
                  w_grant_n = NREQ'(1) << w_nxt_show;
                  w_hold_n  = '0;
               end else if (w_tick && !w_hold_full) begin
                  w_hold_n = r_hold + HW'(1);
               end
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_rr    <= 3'(NREQ - 1);
         r_grant <= '0;
         r_hold  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_n;
         r_cur   <= w_cur_n;
         r_rr    <= w_rr_n;
         r_grant <= w_grant_n;
         r_hold  <= w_hold_n;
         r_data  <= w_data_n;
      end
   end

   assign grant     = r_grant;
   assign cur_src   = r_cur;
   assign disp_data = r_data;
   assign disp_vld  = (r_state == ST_SHOW);
   assign scan_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_disp_arbiter : directed vector table plus corner-case sequences          |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_disp_arbiter;

   localparam int NREQ       = 4;
   localparam int SCAN_DIV   = 4;
   localparam int HOLD_TICKS = 2;
   localparam int NVEC       = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          freeze;
   logic [3:0]    req;
   logic [15:0]   src [4];
   logic [63:0]   src_data;
   logic [3:0]    grant;
   logic [2:0]    cur_src;
   logic [15:0]   disp_data;
   logic          disp_vld;
   logic          scan_tick;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [15:0] data;
      logic        vld;
      logic        tick;
   } vec_t;

   vec_t tv [NVEC];

   assign src_data = {src[3], src[2], src[1], src[0]};

   always #5 clk = ~clk;

   disp_arbiter #(
      .NREQ       (NREQ),
      .SCAN_DIV   (SCAN_DIV),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef DISP_FREEZE_EN
      .freeze    (freeze),
`endif
      .req       (req),
      .src_data  (src_data),
      .grant     (grant),
      .cur_src   (cur_src),
      .disp_data (disp_data),
      .disp_vld  (disp_vld),
      .scan_tick (scan_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [15:0] d, input logic v, input logic t);
      tv[i].rst = r; tv[i].req = rq; tv[i].grant = g;
      tv[i].data = d; tv[i].vld = v; tv[i].tick = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0]  exp_cur;
      logic [15:0] val;

      rst = 1'b1; req = 4'hF; freeze = 1'b0;
      src[0] = 16'h1234; src[1] = 16'h2222; src[2] = 16'hABCD; src[3] = 16'h3333;

      // reset held with all requests up, then source 0 first
      for (int i = 0; i < 3; i++) setv(i, 1'b1, 4'hF, 4'h0, 16'h0000, 1'b0, 1'b0);
      setv(3,  1'b0, 4'hF, 4'h1, 16'h0000, 1'b1, 1'b0);
      // hold alternation between src0 and src2
      setv(4,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(5,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(6,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b1);
      setv(7,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(8,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(9,  1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(10, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b1);
      setv(11, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(12, 1'b0, 4'h5, 4'h4, 16'h1234, 1'b1, 1'b0);
      setv(13, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b0);
      setv(14, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b1);
      setv(15, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b0);
      setv(16, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b0);
      setv(17, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b0);
      setv(18, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b1);
      setv(19, 1'b0, 4'h5, 4'h4, 16'hABCD, 1'b1, 1'b0);
      setv(20, 1'b0, 4'h5, 4'h1, 16'hABCD, 1'b1, 1'b0);
      setv(21, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      // owner drop, idle, re-raise
      setv(22, 1'b0, 4'h2, 4'h2, 16'h1234, 1'b1, 1'b1);
      setv(23, 1'b0, 4'h2, 4'h2, 16'h2222, 1'b1, 1'b0);
      setv(24, 1'b0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0);
      setv(25, 1'b0, 4'h2, 4'h2, 16'h0000, 1'b1, 1'b0);
      setv(26, 1'b0, 4'h2, 4'h2, 16'h2222, 1'b1, 1'b1);
      // src3 owns, drops at hold expiry with req0 set -> wrap to 0
      setv(27, 1'b0, 4'h8, 4'h8, 16'h2222, 1'b1, 1'b0);
      setv(28, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(29, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(30, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b1);
      setv(31, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(32, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(33, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(34, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b1);
      setv(35, 1'b0, 4'h8, 4'h8, 16'h3333, 1'b1, 1'b0);
      setv(36, 1'b0, 4'h1, 4'h1, 16'h3333, 1'b1, 1'b0);
      // hold restarted: src2 waiting must not be granted immediately
      setv(37, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);
      setv(38, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b1);
      setv(39, 1'b0, 4'h5, 4'h1, 16'h1234, 1'b1, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst = tv[i].rst;
         req = tv[i].req;
         step();
         exp_cur = 3'd0;
         for (int k = 0; k < 4; k++) if (tv[i].grant[k]) exp_cur = 3'(k);
         check($sformatf("vec%0d grant", i), 32'(grant), 32'(tv[i].grant));
         check($sformatf("vec%0d cur_src", i), 32'(cur_src), 32'(exp_cur));
         check($sformatf("vec%0d disp_data", i), 32'(disp_data), 32'(tv[i].data));
         check($sformatf("vec%0d disp_vld", i), 32'(disp_vld), 32'(tv[i].vld));
         check($sformatf("vec%0d scan_tick", i), 32'(scan_tick), 32'(tv[i].tick));
      end

      // single requester: held for 20 scan periods, data tracks src1
      @(negedge clk);
      req = 4'h2;
      step();
      check("single first grant", 32'(grant), 32'h2);
      check("single first data", 32'(disp_data), 32'h1234);
      for (int i = 0; i < 20 * SCAN_DIV; i++) begin
         @(negedge clk);
         val = 16'($urandom);
         src[1] = val;
         step();
         check("single grant", 32'(grant), 32'h2);
         check("single data", 32'(disp_data), 32'(val));
      end
      check("single hold saturated", 32'(dut.r_hold), 32'(HOLD_TICKS));
      src[1] = 16'h2222;

      // reset mid-SHOW, then prescaler restarts from zero
      @(negedge clk);
      rst = 1'b1;
      step();
      check("midrst grant", 32'(grant), 32'h0);
      check("midrst data", 32'(disp_data), 32'h0);
      check("midrst vld", 32'(disp_vld), 32'h0);
      check("midrst tick", 32'(scan_tick), 32'h0);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         rst = 1'b0;
         step();
         check("postrst grant", 32'(grant), 32'h2);
         check("postrst tick", 32'(scan_tick), (j == 4) ? 32'h1 : 32'h0);
      end

`ifdef DISP_FREEZE_EN
      @(negedge clk);
      req = 4'h1;
      step();
      check("frz pre grant", 32'(grant), 32'h1);
      @(negedge clk);
      step();
      check("frz pre data", 32'(disp_data), 32'h1234);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         freeze = 1'b1; src[0] = 16'h5555; req = 4'h4;
         step();
         check("frz grant held", 32'(grant), 32'h1);
         check("frz data held", 32'(disp_data), 32'h1234);
      end
      @(negedge clk);
      freeze = 1'b0;
      step();
      check("frz release grant", 32'(grant), 32'h4);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
